// File: rtl/handshake_axis_pkg.sv
// Shared widths, constants and arbiter state type for the
// multi-outstanding kernel-load to AXI-Stream read adapter.
package handshake_axis_pkg;

  localparam logic TLAST_SINGLE = 1'b1;

  typedef enum logic {
    ARB_S,
    HOLD_S
  } arb_state_t;

  function automatic int ch_id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int req_width(input int n, input int aw);
    return ch_id_w(n) + aw;
  endfunction

  function automatic int rsp_width(input int n, input int dw);
    return ch_id_w(n) + dw;
  endfunction

  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/hs_rsp_fifo.sv
// Per-channel response FIFO: registered storage, head visible
// one cycle after push, occupancy exported for credit accounting.
module hs_rsp_fifo
  import handshake_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     empty,
  output logic [cnt_w(DEPTH)-1:0]  occ
);

  localparam int OW = cnt_w(DEPTH);
  localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [OW-1:0]         cnt;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == OW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign occ     = cnt;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case (1'b1)
        (do_push && !do_pop): cnt <= cnt + 1'b1;
        (do_pop && !do_push): cnt <= cnt - 1'b1;
        default:              cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/handshake_to_axi_stream_read_mo.sv
// N kernel load channels -> tagged AXIS request stream, with
// credit-limited multi-outstanding responses routed per channel.
module handshake_to_axi_stream_read_mo
  import handshake_axis_pkg::*;
#(
  parameter int  ADDR_WIDTH      = 2,
  parameter int  DATA_WIDTH      = 64,
  parameter int  N_CHANNELS      = 5,
  parameter int  MAX_OUTSTANDING = 4,
  parameter int  RSP_DEPTH       = 2,
  localparam int CH_ID_W   = ch_id_w(N_CHANNELS),
  localparam int REQ_WIDTH = req_width(N_CHANNELS, ADDR_WIDTH),
  localparam int RSP_WIDTH = rsp_width(N_CHANNELS, DATA_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_CHANNELS*ADDR_WIDTH-1:0] stAddr,
  input  logic [N_CHANNELS-1:0]            stAddr_valid,
  output logic [N_CHANNELS-1:0]            stAddr_ready,
  output logic [N_CHANNELS*DATA_WIDTH-1:0] stData,
  output logic [N_CHANNELS-1:0]            stData_valid,
  input  logic [N_CHANNELS-1:0]            stData_ready,
  output logic [N_CHANNELS-1:0]            stDone_valid,
  input  logic [N_CHANNELS-1:0]            stDone_ready,
  output logic [REQ_WIDTH-1:0]             m_axis_req_tdata,
  output logic                             m_axis_req_tvalid,
  input  logic                             m_axis_req_tready,
  output logic                             m_axis_req_tlast,
  input  logic [RSP_WIDTH-1:0]             s_axis_pl_tdata,
  input  logic                             s_axis_pl_tvalid,
  output logic                             s_axis_pl_tready,
  input  logic                             s_axis_pl_tlast,
  output logic                             err_unexpected
);

  localparam int CW = cnt_w(RSP_DEPTH);
  localparam int GW = cnt_w(MAX_OUTSTANDING);
  localparam int SW = CW + 2;

  typedef logic [CH_ID_W-1:0] ch_id_t;

  localparam ch_id_t LAST_CH = ch_id_t'(N_CHANNELS - 1);

  arb_state_t            state_q;
  arb_state_t            state_d;
  ch_id_t                rr_q;
  ch_id_t                lock_id_q;
  ch_id_t                pick_id;
  ch_id_t                gnt_id;
  ch_id_t                rsp_id;
  logic                  any_elig;
  logic                  cap_ok;
  logic                  accept;
  logic                  beat;
  logic                  any_push;
  logic                  err_q;
  logic                  unused_tlast;
  logic [GW-1:0]         global_q;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [N_CHANNELS-1:0] elig;
  logic [N_CHANNELS-1:0] live;
  logic [N_CHANNELS-1:0] accept_c;
  logic [N_CHANNELS-1:0] push_c;
  logic [N_CHANNELS-1:0] pop_c;
  logic [N_CHANNELS-1:0] dh_c;

  assign unused_tlast = s_axis_pl_tlast;

  assign cap_ok   = (global_q < GW'(MAX_OUTSTANDING));
  assign accept   = m_axis_req_tvalid && m_axis_req_tready;
  assign rsp_id   = s_axis_pl_tdata[RSP_WIDTH-1 -: CH_ID_W];
  assign rsp_data = s_axis_pl_tdata[DATA_WIDTH-1:0];
  assign beat     = s_axis_pl_tvalid && s_axis_pl_tready;
  assign any_push = |push_c;

  assign s_axis_pl_tready = (global_q != '0);
  assign m_axis_req_tlast = TLAST_SINGLE;
  assign m_axis_req_tdata = {gnt_id, addr_sel};
  assign err_unexpected   = err_q;

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] done_q;
    logic [CW-1:0] occ;
    logic [SW-1:0] used;
    logic          empty;

    // Credit covers in-flight, buffered and un-consumed done tokens.
    assign used = SW'(inflight_q) + SW'(occ) + SW'(done_q);

    assign elig[c]         = stAddr_valid[c] && (used < SW'(RSP_DEPTH))
                             && cap_ok;
    assign live[c]         = (inflight_q != '0);
    assign accept_c[c]     = accept && (gnt_id == ch_id_t'(c));
    assign stAddr_ready[c] = accept_c[c];
    assign push_c[c]       = beat && live[c] && (rsp_id == ch_id_t'(c));
    assign stData_valid[c] = !empty;
    assign stDone_valid[c] = (done_q != '0);
    assign pop_c[c]        = stData_valid[c] && stData_ready[c];
    assign dh_c[c]         = stDone_valid[c] && stDone_ready[c];

    hs_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RSP_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c[c]),
      .wdata (rsp_data),
      .pop   (pop_c[c]),
      .rdata (stData[c*DATA_WIDTH +: DATA_WIDTH]),
      .empty (empty),
      .occ   (occ)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        inflight_q <= '0;
        done_q     <= '0;
      end else begin
        unique case (1'b1)
          (accept_c[c] && !push_c[c]): inflight_q <= inflight_q + 1'b1;
          (push_c[c] && !accept_c[c]): inflight_q <= inflight_q - 1'b1;
          default:                     inflight_q <= inflight_q;
        endcase
        unique case (1'b1)
          (pop_c[c] && !dh_c[c]): done_q <= done_q + 1'b1;
          (dh_c[c] && !pop_c[c]): done_q <= done_q - 1'b1;
          default:                done_q <= done_q;
        endcase
      end
    end
  end

  always_comb begin
    int     idx;
    ch_id_t cand;
    idx      = 0;
    cand     = '0;
    pick_id  = '0;
    any_elig = 1'b0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_CHANNELS) begin
        idx = idx - N_CHANNELS;
      end
      cand = ch_id_t'(idx);
      if (!any_elig && elig[cand]) begin
        any_elig = 1'b1;
        pick_id  = cand;
      end
    end
  end

  always_comb begin
    addr_sel = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (gnt_id == ch_id_t'(c)) begin
        addr_sel = stAddr[c*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // HOLD keeps a stalled grant and its tdata stable until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_S;
      lock_id_q <= '0;
    end else begin
      state_q <= state_d;
      if (m_axis_req_tvalid && !m_axis_req_tready) begin
        lock_id_q <= gnt_id;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_S: begin
        if (m_axis_req_tvalid && !m_axis_req_tready) begin
          state_d = HOLD_S;
        end
      end
      HOLD_S: begin
        if (m_axis_req_tready) begin
          state_d = ARB_S;
        end
      end
      default: state_d = ARB_S;
    endcase
  end

  always_comb begin
    m_axis_req_tvalid = 1'b0;
    gnt_id            = pick_id;
    unique case (state_q)
      ARB_S: begin
        m_axis_req_tvalid = any_elig;
      end
      HOLD_S: begin
        m_axis_req_tvalid = 1'b1;
        gnt_id            = lock_id_q;
      end
      default: begin
        m_axis_req_tvalid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= '0;
      global_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        rr_q <= (gnt_id == LAST_CH) ? '0 : gnt_id + 1'b1;
      end
      unique case (1'b1)
        (accept && !any_push): global_q <= global_q + 1'b1;
        (any_push && !accept): global_q <= global_q - 1'b1;
        default:               global_q <= global_q;
      endcase
      if (beat && !any_push) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
